// File: rtl/ets_pkg.sv
// Shared definitions for the ETS sweep engine: FSM states, phase-shift
// direction constants and the step-count clamp.
package ets_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SHIFT  = 3'd1,
      S_SETTLE = 3'd2,
      S_ACQ    = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5,
      S_UNWIND = 3'd6
   } ets_state_t;

   localparam logic PS_INC = 1'b1;
   localparam logic PS_DEC = 1'b0;

   // Limit the requested step count so one sweep never overflows a buffer bank.
   function automatic int unsigned clamp_steps(input int unsigned req_steps,
                                               input int unsigned max_steps);
      return (req_steps < max_steps) ? req_steps : max_steps;
   endfunction

endpackage

// File: rtl/ets_ps_driver.sv
// MMCM dynamic phase-shift handshake: one request in flight at a time,
// bounded wait for ps_done, and a running net phase count.
module ets_ps_driver
   import ets_pkg::*;
#(
   parameter int PS_TMO = 1023
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        req,
   input  logic        dir,
   input  logic        ps_done,
   output logic        ps_en,
   output logic        ps_incdec,
   output logic        ack,
   output logic        timeout,
   output logic [31:0] phase_counter
);

   localparam int TMO_W = $clog2(PS_TMO + 1);

   logic             pending_q;
   logic [TMO_W-1:0] tmo_cnt_q;

   // ps_done only counts while a request is outstanding; the cycle after ps_en is count 1.
   assign ack     = pending_q & ps_done;
   assign timeout = pending_q & ~ps_done & (tmo_cnt_q == TMO_W'(PS_TMO));

   // Issue a single-cycle ps_en, then wait for the acknowledge or give up after PS_TMO cycles.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         ps_en         <= 1'b0;
         ps_incdec     <= 1'b0;
         pending_q     <= 1'b0;
         tmo_cnt_q     <= '0;
         phase_counter <= 32'd0;
      end else begin
         ps_en <= 1'b0;
         if (!pending_q) begin
            if (req) begin
               ps_en     <= 1'b1;
               ps_incdec <= dir;
               pending_q <= 1'b1;
               tmo_cnt_q <= '0;
            end
         end else if (ps_done) begin
            pending_q     <= 1'b0;
            phase_counter <= (ps_incdec == PS_INC) ? phase_counter + 32'd1
                                                   : phase_counter - 32'd1;
         end else if (timeout) begin
            pending_q <= 1'b0;
         end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
         end
      end
   end

endmodule

// File: rtl/ets_sweep_engine.sv
// Equivalent-time-sampling sweep sequencer: steps the MMCM phase, counts
// comparator hits per channel over avg_cnt triggers, and writes one word per
// channel per step into a ping-pong sample buffer.
module ets_sweep_engine
   import ets_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 16,
   parameter int STEP_W     = 10,
   parameter int ADDR_W     = 9,
   parameter int DATA_W     = 32,
   parameter int SETTLE_CYC = 16,
   parameter int PS_TMO     = 1023
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic              en,
   input  logic              mode_cont,
   input  logic [CNT_W-1:0]  avg_cnt,
   input  logic [STEP_W-1:0] num_steps,
   input  logic              trigger,
   input  logic [NUM_CH-1:0] cmp_data,
   output logic              ps_en,
   output logic              ps_incdec,
   input  logic              ps_done,
   output logic              wr_en,
   output logic [ADDR_W:0]   wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_buf_id,
   output logic [31:0]       phase_counter,
   output logic              busy,
   output logic              sweep_done,
   output logic              ps_err
);

   localparam int MAX_STEPS = (2 ** ADDR_W) / NUM_CH;
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int SET_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   ets_state_t        state_q, state_d;
   logic              en_q, trigger_q, mode_q, wr_buf_q, ps_err_q;
   logic [CNT_W-1:0]  avg_q, trig_cnt_q;
   logic [STEP_W-1:0] steps_q, step_q, step_nxt, steps_in;
   logic [SET_W-1:0]  settle_cnt_q;
   logic [CH_W-1:0]   wr_ch_q;
   logic [CNT_W-1:0]  acc_q [NUM_CH];
   logic              ps_req, ps_dir, ps_ack, ps_tmo;
   logic              en_rise, trig_rise, start, restart;
   logic              trig_last, settle_last, wr_last;

   // Hit counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] acc, input logic hit);
      if (hit && (acc != {CNT_W{1'b1}}))
         return acc + CNT_W'(1);
      return acc;
   endfunction

   assign steps_in    = STEP_W'(clamp_steps(32'(num_steps), MAX_STEPS));
   assign en_rise     = en & ~en_q;
   assign trig_rise   = trigger & ~trigger_q;
   assign start       = (state_q == S_IDLE) && en_rise && (steps_in != '0);
   assign restart     = (state_q == S_DONE) && mode_q && en;
   assign trig_last   = (trig_cnt_q == avg_q - CNT_W'(1));
   assign settle_last = (settle_cnt_q == SET_W'(SETTLE_CYC - 1));
   assign wr_last     = (wr_ch_q == CH_W'(NUM_CH - 1));
   assign step_nxt    = step_q + STEP_W'(1);

   assign wr_en      = (state_q == S_WRITE);
   assign wr_addr    = {wr_buf_q, ADDR_W'(32'(step_q) * 32'(NUM_CH) + 32'(wr_ch_q))};
   assign wr_data    = DATA_W'(acc_q[wr_ch_q]);
   assign wr_buf_id  = wr_buf_q;
   assign busy       = (state_q != S_IDLE);
   assign sweep_done = (state_q == S_DONE);
   assign ps_err     = ps_err_q;

   ets_ps_driver #(
      .PS_TMO(PS_TMO)
   ) u_ps_driver (
      .sys_clk      (sys_clk),
      .reset        (reset),
      .req          (ps_req),
      .dir          (ps_dir),
      .ps_done      (ps_done),
      .ps_en        (ps_en),
      .ps_incdec    (ps_incdec),
      .ack          (ps_ack),
      .timeout      (ps_tmo),
      .phase_counter(phase_counter)
   );

   // State register.
   always_ff @(posedge sys_clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic and phase-shift requests; a pending MMCM handshake is always finished.
   always_comb begin
      state_d = state_q;
      ps_req  = 1'b0;
      ps_dir  = PS_INC;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_ACQ;
         S_SHIFT: begin
            ps_req = 1'b1;
            if (ps_tmo)      state_d = S_IDLE;
            else if (ps_ack) state_d = en ? S_SETTLE : S_UNWIND;
         end
         S_SETTLE: begin
            if (!en)              state_d = S_UNWIND;
            else if (settle_last) state_d = S_ACQ;
         end
         S_ACQ: begin
            if (!en)                         state_d = S_UNWIND;
            else if (trig_rise && trig_last) state_d = S_WRITE;
         end
         S_WRITE: begin
            if (!en)          state_d = S_UNWIND;
            else if (wr_last) state_d = (step_nxt < steps_q) ? S_SHIFT : S_DONE;
         end
         S_DONE:   state_d = restart ? S_SHIFT : S_UNWIND;
         S_UNWIND: begin
            ps_dir = PS_DEC;
            ps_req = (phase_counter != 32'd0);
            if (ps_tmo)                      state_d = S_IDLE;
            else if (phase_counter == 32'd0) state_d = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   // Sweep bookkeeping: latched settings, step index, settle timer, accumulators, bank and fault flag.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         en_q         <= 1'b0;
         trigger_q    <= 1'b0;
         mode_q       <= 1'b0;
         wr_buf_q     <= 1'b0;
         ps_err_q     <= 1'b0;
         avg_q        <= CNT_W'(1);
         trig_cnt_q   <= '0;
         steps_q      <= '0;
         step_q       <= '0;
         settle_cnt_q <= '0;
         wr_ch_q      <= '0;
         for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= '0;
      end else begin
         en_q      <= en;
         trigger_q <= trigger;
         if (ps_tmo) ps_err_q <= 1'b1;
         case (state_q)
            S_IDLE: if (start) begin
               avg_q      <= (avg_cnt == '0) ? CNT_W'(1) : avg_cnt;
               steps_q    <= steps_in;
               mode_q     <= mode_cont;
               step_q     <= '0;
               trig_cnt_q <= '0;
               wr_ch_q    <= '0;
               for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= '0;
            end
            S_SHIFT:  settle_cnt_q <= '0;
            S_SETTLE: settle_cnt_q <= settle_cnt_q + SET_W'(1);
            S_ACQ: if (trig_rise) begin
               trig_cnt_q <= trig_cnt_q + CNT_W'(1);
               for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= sat_inc(acc_q[ch], cmp_data[ch]);
            end
            S_WRITE: begin
               if (wr_last) begin
                  wr_ch_q    <= '0;
                  trig_cnt_q <= '0;
                  step_q     <= step_nxt;
                  for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= '0;
               end else begin
                  wr_ch_q <= wr_ch_q + CH_W'(1);
               end
            end
            S_DONE: if (restart) begin
               wr_buf_q <= ~wr_buf_q;
               step_q   <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ets_sweep_engine.sv
// Directed bench for ets_sweep_engine with a simple MMCM acknowledge model.
module tb_ets_sweep_engine;

   localparam int NUM_CH     = 4;
   localparam int CNT_W      = 16;
   localparam int STEP_W     = 10;
   localparam int ADDR_W     = 9;
   localparam int DATA_W     = 32;
   localparam int SETTLE_CYC = 16;
   localparam int PS_TMO     = 1023;

   logic              sys_clk = 1'b0;
   logic              reset, en, mode_cont, trigger, ps_done;
   logic [CNT_W-1:0]  avg_cnt;
   logic [STEP_W-1:0] num_steps;
   logic [NUM_CH-1:0] cmp_data;
   logic              ps_en, ps_incdec, wr_en, wr_buf_id, busy, sweep_done, ps_err;
   logic [ADDR_W:0]   wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [31:0]       phase_counter;

   int total = 0;
   int bad   = 0;

   logic              mmcm_on = 1'b0;
   logic [ADDR_W:0]   log_addr [$];
   logic [DATA_W-1:0] log_data [$];
   int                inc_n = 0, dec_n = 0, done_n = 0;
   int                epoch = 0, seen_epoch = 0;
   logic [31:0]       pmax = 32'd0;

   ets_sweep_engine #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .STEP_W(STEP_W), .ADDR_W(ADDR_W),
      .DATA_W(DATA_W), .SETTLE_CYC(SETTLE_CYC), .PS_TMO(PS_TMO)
   ) dut (
      .sys_clk(sys_clk), .reset(reset), .en(en), .mode_cont(mode_cont),
      .avg_cnt(avg_cnt), .num_steps(num_steps), .trigger(trigger), .cmp_data(cmp_data),
      .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_buf_id(wr_buf_id),
      .phase_counter(phase_counter), .busy(busy), .sweep_done(sweep_done), .ps_err(ps_err)
   );

   always #5 sys_clk = ~sys_clk;

   // MMCM model: ps_done pulses a fixed number of cycles after each ps_en.
   initial begin : mmcm_model
      int dly;
      dly = 0;
      ps_done = 1'b0;
      forever begin
         @(posedge sys_clk);
         #1;
         ps_done = 1'b0;
         if (dly > 0) begin
            dly--;
            if (dly == 0) ps_done = 1'b1;
         end else if (ps_en === 1'b1 && mmcm_on) begin
            dly = 5;
         end
      end
   end

   // Output logger.
   initial begin : monitor
      forever begin
         @(negedge sys_clk);
         if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            pmax = 32'd0;
         end
         if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
         end
         if (ps_en === 1'b1) begin
            if (ps_incdec) inc_n++;
            else           dec_n++;
         end
         if (sweep_done === 1'b1) done_n++;
         if (phase_counter > pmax) pmax = phase_counter;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; en = 1'b0; mode_cont = 1'b0; trigger = 1'b0;
      cmp_data = '0; avg_cnt = '0; num_steps = '0;
      repeat (3) @(posedge sys_clk);
      #1 reset = 1'b0;
   endtask

   task automatic start_sweep(input int steps, input int avg, input logic cont);
      @(posedge sys_clk);
      #1;
      num_steps = STEP_W'(steps);
      avg_cnt   = CNT_W'(avg);
      mode_cont = cont;
      en        = 1'b1;
   endtask

   task automatic pulse_trig(input logic [NUM_CH-1:0] c);
      @(posedge sys_clk);
      #1;
      cmp_data = c;
      trigger  = 1'b1;
      @(posedge sys_clk);
      #1;
      trigger  = 1'b0;
   endtask

   // Wait for the MMCM acknowledge, then for settling to finish so ACQ is active.
   task automatic wait_ps_done(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (ps_done !== 1'b1 && n < 300);
      check(tag, ps_done, 1);
      repeat (SETTLE_CYC + 4) @(posedge sys_clk);
   endtask

   task automatic wait_ps_en(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (ps_en !== 1'b1 && n < 100);
      check(tag, ps_en, 1);
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      int n;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (busy !== 1'b0 && n < max_cyc);
      check(tag, busy, 0);
   endtask

   initial begin : stimulus
      int bw, bi, bd, bs, cnt, oos;
      logic [NUM_CH-1:0] c;

      // ---- reset state ----
      do_reset();
      @(negedge sys_clk);
      check("rst_busy", busy, 0);
      check("rst_ps_en", ps_en, 0);
      check("rst_ps_incdec", ps_incdec, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_wr_buf_id", wr_buf_id, 0);
      check("rst_phase", phase_counter, 0);
      check("rst_sweep_done", sweep_done, 0);
      check("rst_ps_err", ps_err, 0);

      // ---- 1: single sweep, 3 steps x 4 triggers ----
      mmcm_on = 1'b1;
      epoch++;
      bw = log_addr.size(); bi = inc_n; bd = dec_n; bs = done_n;
      start_sweep(3, 4, 1'b0);
      for (int s = 0; s < 3; s++) begin
         if (s > 0) wait_ps_done("t1_ack");
         repeat (4) pulse_trig(4'b1010);
      end
      wait_idle("t1_idle", 600);
      check("t1_nwr", log_addr.size() - bw, 12);
      for (int i = 0; i < 12; i++) begin
         if (bw + i < log_addr.size()) begin
            check("t1_addr", log_addr[bw + i], i);
            check("t1_data", log_data[bw + i], (i % 2 == 1) ? 4 : 0);
         end
      end
      check("t1_pmax", pmax, 2);
      check("t1_inc", inc_n - bi, 2);
      check("t1_dec", dec_n - bd, 2);
      check("t1_phase", phase_counter, 0);
      check("t1_done", done_n - bs, 1);
      check("t1_err", ps_err, 0);

      // ---- 2: ps_done never returned ----
      do_reset();
      mmcm_on = 1'b0;
      bw = log_addr.size();
      start_sweep(2, 1, 1'b0);
      pulse_trig(4'b1111);
      wait_ps_en("t2_ps_en");
      check("t2_incdec", ps_incdec, 1);
      cnt = 0;
      do begin
         @(negedge sys_clk);
         cnt++;
      end while (ps_err !== 1'b1 && cnt < 1100);
      check("t2_tmo_cycles", cnt, PS_TMO + 1);
      check("t2_err", ps_err, 1);
      check("t2_idle", busy, 0);
      check("t2_phase", phase_counter, 0);
      check("t2_nwr", log_addr.size() - bw, 4);
      repeat (5) @(negedge sys_clk);
      check("t2_err_sticky", ps_err, 1);
      @(posedge sys_clk);
      #1 en = 1'b0;

      // ---- 3: avg_cnt=0 behaves as 1, single step, no shift ----
      do_reset();
      mmcm_on = 1'b1;
      epoch++;
      bw = log_addr.size(); bi = inc_n; bs = done_n;
      c = 4'b0110;
      start_sweep(1, 0, 1'b0);
      pulse_trig(c);
      wait_idle("t3_idle", 100);
      check("t3_nwr", log_addr.size() - bw, 4);
      for (int i = 0; i < 4; i++) begin
         if (bw + i < log_addr.size()) begin
            check("t3_addr", log_addr[bw + i], i);
            check("t3_data", log_data[bw + i], c[i]);
         end
      end
      check("t3_no_shift", inc_n - bi, 0);
      check("t3_done", done_n - bs, 1);
      check("t3_phase", phase_counter, 0);

      // ---- 4: continuous mode, bank toggle, abort in ACQ ----
      do_reset();
      epoch++;
      bw = log_addr.size(); bi = inc_n; bd = dec_n; bs = done_n;
      start_sweep(2, 1, 1'b1);
      pulse_trig(4'b0001);
      wait_ps_done("t4_ack1");
      pulse_trig(4'b0001);
      wait_ps_done("t4_ack2");
      check("t4_buf", wr_buf_id, 1);
      check("t4_done1", done_n - bs, 1);
      pulse_trig(4'b0011);
      wait_ps_done("t4_ack3");
      pulse_trig(4'b0011);
      wait_ps_done("t4_ack4");
      check("t4_phase_peak", phase_counter, 4);
      @(posedge sys_clk);
      #1 en = 1'b0;
      wait_idle("t4_idle", 300);
      check("t4_nwr", log_addr.size() - bw, 16);
      if (bw + 7 < log_addr.size()) check("t4_addr_bank0", log_addr[bw + 7], 7);
      for (int i = 8; i < 16; i++) begin
         if (bw + i < log_addr.size()) begin
            check("t4_addr_bank1", log_addr[bw + i], 512 + i - 8);
            check("t4_data_bank1", log_data[bw + i], ((i % 4) < 2) ? 1 : 0);
         end
      end
      check("t4_phase", phase_counter, 0);
      check("t4_inc", inc_n - bi, 4);
      check("t4_dec", dec_n - bd, 4);
      check("t4_done", done_n - bs, 2);
      check("t4_pmax", pmax, 4);

      // ---- 5: num_steps clamped to 128 ----
      do_reset();
      epoch++;
      bw = log_addr.size(); bs = done_n;
      start_sweep(1000, 1, 1'b0);
      for (int s = 0; s < 128; s++) begin
         if (s > 0) wait_ps_done("t5_ack");
         pulse_trig(4'b0001);
      end
      wait_idle("t5_idle", 3000);
      check("t5_nwr", log_addr.size() - bw, 512);
      oos = 0;
      for (int i = 0; i < 512; i++) begin
         if (bw + i < log_addr.size()) begin
            if (log_addr[bw + i] !== (ADDR_W + 1)'(i)) oos++;
         end
      end
      check("t5_addr_seq", oos, 0);
      if (log_addr.size() > 0) check("t5_last_addr", log_addr[log_addr.size() - 1], 511);
      check("t5_pmax", pmax, 127);
      check("t5_phase", phase_counter, 0);
      check("t5_done", done_n - bs, 1);

      // ---- 6: en dropped while waiting for ps_done ----
      do_reset();
      epoch++;
      bi = inc_n; bd = dec_n; bs = done_n;
      start_sweep(2, 1, 1'b0);
      pulse_trig(4'b0001);
      wait_ps_en("t6_ps_en");
      @(posedge sys_clk);
      #1 en = 1'b0;
      @(negedge sys_clk);
      check("t6_busy_hold", busy, 1);
      wait_idle("t6_idle", 200);
      check("t6_inc", inc_n - bi, 1);
      check("t6_dec", dec_n - bd, 1);
      check("t6_pmax", pmax, 1);
      check("t6_phase", phase_counter, 0);
      check("t6_no_done", done_n - bs, 0);
      check("t6_err", ps_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
